// File: rtl/timer_ctrl.sv
// timer_ctrl: pushbutton-driven countdown timer controller with an alarm and a flashing display.
// Define TIMER_CTRL_DEBOUNCE_EN to debounce both buttons over DB_CYCLES clocks.
module timer_ctrl #(
  parameter int DB_CYCLES    = 50000,
  parameter int ALARM_CYCLES = 25000000,
  parameter int FLASH_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_set,
  input  logic       btn_start,
  input  logic       tmr_zero,
  output logic       tmr_load,
  output logic       tmr_en,
  output logic       alarm,
  output logic       disp_blank,
  output logic [2:0] state
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOADED = 3'd1;
  localparam logic [2:0] RUN    = 3'd2;
  localparam logic [2:0] PAUSE  = 3'd3;
  localparam logic [2:0] ALARM  = 3'd4;
  localparam int AW = $clog2(ALARM_CYCLES + 1);
  localparam int FW = $clog2(FLASH_CYCLES + 1);

  logic [1:0] btn, s1_q, s2_q, vld_q, cond, prev_q, arm_q, ev;
  logic       set_ev, start_ev;

  assign btn = {btn_start, btn_set};

  // arm_q stays low until a button is seen released, so a press held through reset is ignored
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      vld_q  <= '0;
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      vld_q  <= {vld_q[0], 1'b1};
      prev_q <= cond;
      arm_q  <= arm_q | ({2{vld_q[1]}} & ~s2_q);
    end
  end

`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DW-1:0] cnt_q;
    logic          c_q;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        cnt_q <= '0;
        c_q   <= 1'b0;
      end else if (s2_q[i] != c_q) begin
        cnt_q <= (cnt_q == DW'(DB_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
        c_q   <= (cnt_q == DW'(DB_CYCLES - 1)) ? s2_q[i] : c_q;
      end else begin
        cnt_q <= '0;
      end
    end
    assign cond[i] = c_q;
  end
`else
  assign cond = s2_q;
`endif

  assign ev       = cond & ~prev_q & arm_q;
  assign set_ev   = ev[0];
  assign start_ev = ev[1];

  logic [2:0]    state_q, state_d;
  logic          load_d, blank_q, blank_d, stay;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          load_q, en_q, alarm_q;

  always_comb begin
    state_d = state_q;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = set_ev ? LOADED : IDLE;
        load_d  = set_ev;
      end
      LOADED: begin
        state_d = (!set_ev && start_ev) ? RUN : LOADED;
        load_d  = set_ev;
      end
      RUN: begin
        state_d = tmr_zero ? ALARM : set_ev ? LOADED : start_ev ? PAUSE : RUN;
        load_d  = !tmr_zero && set_ev;
      end
      PAUSE: begin
        state_d = set_ev ? LOADED : start_ev ? RUN : PAUSE;
        load_d  = set_ev;
      end
      ALARM: state_d = (set_ev || start_ev || acnt_q == AW'(ALARM_CYCLES - 1)) ? IDLE : ALARM;
      default: state_d = IDLE;
    endcase
  end

  // both alarm counters restart from zero on every ALARM entry
  assign stay    = (state_q == ALARM) && (state_d == ALARM);
  assign acnt_d  = stay ? acnt_q + 1'b1 : '0;
  assign fcnt_d  = (stay && fcnt_q != FW'(FLASH_CYCLES - 1)) ? fcnt_q + 1'b1 : '0;
  assign blank_d = stay && (blank_q ^ (fcnt_q == FW'(FLASH_CYCLES - 1)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      alarm_q <= 1'b0;
      blank_q <= 1'b0;
      acnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      en_q    <= state_d == RUN;
      alarm_q <= state_d == ALARM;
      blank_q <= blank_d;
      acnt_q  <= acnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state      = state_q;
  assign tmr_load   = load_q;
  assign tmr_en     = en_q;
  assign alarm      = alarm_q;
  assign disp_blank = blank_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl with short debounce/alarm/flash windows.
module tb_timer_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, btn_set = 1'b0, btn_start = 1'b0, tmr_zero = 1'b0;
  logic       tmr_load, tmr_en, alarm, disp_blank;
  logic [2:0] state;
  int errors = 0, checks = 0;
  int n_load = 0, run_len = 0, max_run = 0, n0;

`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam bit DB = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit DB = 1'b0;
`endif

  timer_ctrl #(.DB_CYCLES(4), .ALARM_CYCLES(20), .FLASH_CYCLES(5)) dut (
    .clk(clk), .rstn(rstn), .btn_set(btn_set), .btn_start(btn_start), .tmr_zero(tmr_zero),
    .tmr_load(tmr_load), .tmr_en(tmr_en), .alarm(alarm), .disp_blank(disp_blank), .state(state)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    n_load  <= n_load + (tmr_load ? 1 : 0);
    run_len <= tmr_load ? run_len + 1 : 0;
    max_run <= (tmr_load && run_len + 1 > max_run) ? run_len + 1 : max_run;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input bit s, input bit st, input int hold);
    btn_set = s;
    btn_start = st;
    tick(hold);
    btn_set = 1'b0;
    btn_start = 1'b0;
    tick(14);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick(3);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if ({tmr_load, tmr_en, alarm, disp_blank} !== 4'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0000", {tmr_load, tmr_en, alarm, disp_blank}); end
    rstn = 1'b1;
    tick(5);
  endtask

  task automatic test_set;
    n0 = n_load;
    btn_set = 1'b1;
    tick(LAT - 1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL set_early: got %0d expected 0", state); end
    tick(1);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL set_state: got %0d expected 1", state); end
    checks++; if (tmr_load !== 1'b1) begin errors++; $display("FAIL set_load: got %b expected 1", tmr_load); end
    checks++; if (tmr_en !== 1'b0) begin errors++; $display("FAIL set_en: got %b expected 0", tmr_en); end
    tick(1);
    checks++; if (tmr_load !== 1'b0) begin errors++; $display("FAIL set_load_end: got %b expected 0", tmr_load); end
    tick(10 - LAT - 1);
    btn_set = 1'b0;
    tick(14);
    checks++; if (n_load - n0 !== 1) begin errors++; $display("FAIL set_load_count: got %0d expected 1", n_load - n0); end
  endtask

  task automatic test_start;
    push(0, 1, 10);
    checks++; if ({state, tmr_en} !== {3'd2, 1'b1}) begin errors++; $display("FAIL start_run: got state=%0d en=%b expected 2/1", state, tmr_en); end
    push(0, 1, 10);
    checks++; if ({state, tmr_en} !== {3'd3, 1'b0}) begin errors++; $display("FAIL start_pause: got state=%0d en=%b expected 3/0", state, tmr_en); end
    push(0, 1, 10);
    checks++; if ({state, tmr_en} !== {3'd2, 1'b1}) begin errors++; $display("FAIL start_resume: got state=%0d en=%b expected 2/1", state, tmr_en); end
  endtask

  task automatic test_alarm;
    tmr_zero = 1'b1;
    tick(1);
    tmr_zero = 1'b0;
    checks++; if ({state, alarm, tmr_en, disp_blank} !== {3'd4, 3'b100}) begin errors++; $display("FAIL alarm_entry: got state=%0d alarm=%b en=%b blank=%b expected 4/1/0/0", state, alarm, tmr_en, disp_blank); end
    for (int i = 1; i < 20; i++) begin
      tick(1);
      checks++; if ({state, disp_blank} !== {3'd4, 1'((i / 5) % 2)}) begin errors++; $display("FAIL alarm_flash[%0d]: got state=%0d blank=%b expected 4/%0d", i, state, disp_blank, (i / 5) % 2); end
    end
    tick(1);
    checks++; if ({state, alarm, disp_blank} !== {3'd0, 2'b00}) begin errors++; $display("FAIL alarm_timeout: got state=%0d alarm=%b blank=%b expected 0/0/0", state, alarm, disp_blank); end
  endtask

  task automatic test_priority;
    push(1, 0, 10);
    push(0, 1, 10);
    n0 = n_load;
    btn_set = 1'b1;
    tick(LAT - 1);
    tmr_zero = 1'b1;
    tick(1);
    tmr_zero = 1'b0;
    checks++; if ({state, tmr_load} !== {3'd4, 1'b0}) begin errors++; $display("FAIL zero_over_set: got state=%0d load=%b expected 4/0", state, tmr_load); end
    btn_set = 1'b0;
    btn_start = 1'b1;
    tick(LAT);
    checks++; if ({state, alarm} !== {3'd0, 1'b0}) begin errors++; $display("FAIL alarm_event_exit: got state=%0d alarm=%b expected 0/0", state, alarm); end
    btn_start = 1'b0;
    tick(14);
    checks++; if (n_load - n0 !== 0) begin errors++; $display("FAIL zero_over_set_loads: got %0d expected 0", n_load - n0); end
    push(1, 0, 10);
    push(0, 1, 10);
    push(0, 1, 10);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL pause_reached: got %0d expected 3", state); end
    n0 = n_load;
    push(1, 1, 10);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL set_over_start: got %0d expected 1", state); end
    checks++; if (n_load - n0 !== 1) begin errors++; $display("FAIL set_over_start_loads: got %0d expected 1", n_load - n0); end
  endtask

  task automatic test_glitch;
    n0 = n_load;
    push(1, 0, 3);
    checks++; if (n_load - n0 !== (DB ? 0 : 1)) begin errors++; $display("FAIL glitch3: got %0d expected %0d", n_load - n0, DB ? 0 : 1); end
    n0 = n_load;
    push(1, 0, DB ? 4 : 1);
    checks++; if (n_load - n0 !== 1) begin errors++; $display("FAIL short_press: got %0d expected 1", n_load - n0); end
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL short_press_state: got %0d expected 1", state); end
  endtask

  task automatic test_hold_reset;
    n0 = n_load;
    btn_set = 1'b1;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(20);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL held_through_reset: got %0d expected 0", state); end
    checks++; if (n_load - n0 !== 0) begin errors++; $display("FAIL held_through_reset_loads: got %0d expected 0", n_load - n0); end
    btn_set = 1'b0;
    tick(14);
    push(1, 0, 10);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL repress_after_reset: got %0d expected 1", state); end
  endtask

  task automatic test_reset_alarm;
    push(0, 1, 10);
    tmr_zero = 1'b1;
    tick(1);
    tmr_zero = 1'b0;
    tick(6);
    checks++; if ({state, disp_blank} !== {3'd4, 1'b1}) begin errors++; $display("FAIL pre_reset_alarm: got state=%0d blank=%b expected 4/1", state, disp_blank); end
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    checks++; if ({state, alarm, disp_blank, tmr_en} !== {3'd0, 3'b000}) begin errors++; $display("FAIL reset_in_alarm: got state=%0d alarm=%b blank=%b en=%b expected 0/0/0/0", state, alarm, disp_blank, tmr_en); end
    tick(5);
  endtask

  task automatic test_load_width;
    checks++; if (max_run !== 1) begin errors++; $display("FAIL load_width: got %0d expected 1", max_run); end
  endtask

  initial begin
    test_reset;
    test_set;
    test_start;
    test_alarm;
    test_priority;
    test_glitch;
    test_hold_reset;
    test_reset_alarm;
    test_load_width;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
